// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset constants, fetch FSM states and the IF/ID
// pipeline record consumed by decode.
package cpu_pkg;

  localparam int ADDR_WIDTH  = 32;
  localparam int INSTR_WIDTH = 32;

  localparam logic [ADDR_WIDTH-1:0]  RESET_PC  = 32'h0000_0000;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [ADDR_WIDTH-1:0]  pc_plus4;
    logic                   valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_next_pc_sel.sv
// Combinational next-PC selection: redirect target, alignment check and the
// per-edge priority between redirect, stall, flush and sequential fetch.
module next_pc_sel
  import cpu_pkg::*;
#(
  parameter int AW = ADDR_WIDTH
) (
  input  fetch_state_t  state_i,
  input  logic [AW-1:0] pc_i,
  input  logic [AW-1:0] id_pc_i,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          pc_src_i,
  input  logic          jalr_pc_src_i,
  input  logic [AW-1:0] imm_op_i,
  input  logic [AW-1:0] rs1_data_i,
  output logic [AW-1:0] next_pc_o,
  output logic          bubble_o,
  output logic          hold_o,
  output logic          go_halt_o
);

  logic          redirect;
  logic [AW-1:0] target;
  logic [AW-1:0] jalr_sum;
  logic [AW-1:0] pc_plus4;

  assign redirect = pc_src_i | jalr_pc_src_i;
  assign jalr_sum = rs1_data_i + imm_op_i;
  assign target   = jalr_pc_src_i ? {jalr_sum[AW-1:1], 1'b0} : (id_pc_i + imm_op_i);
  assign pc_plus4 = pc_i + AW'(4);

  // Stall with flush keeps the PC but still kills the IF/ID contents.
  always_comb begin
    next_pc_o = pc_i;
    bubble_o  = 1'b0;
    hold_o    = 1'b0;
    go_halt_o = 1'b0;
    if (state_i == HALT) begin
      bubble_o = 1'b1;
    end else if (redirect && (target[1:0] != 2'b00)) begin
      bubble_o  = 1'b1;
      go_halt_o = 1'b1;
    end else if (redirect) begin
      next_pc_o = target;
      bubble_o  = 1'b1;
    end else if (stall_i) begin
      bubble_o = flush_i;
      hold_o   = ~flush_i;
    end else if (flush_i) begin
      next_pc_o = pc_plus4;
      bubble_o  = 1'b1;
    end else begin
      next_pc_o = pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, the IF/ID pipeline register, the
// RUN/HALT state and the count of valid fetched instructions.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                      ADDR_WIDTH  = cpu_pkg::ADDR_WIDTH,
  parameter int                      INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC    = cpu_pkg::RESET_PC,
  parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = cpu_pkg::NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   pc_src,
  input  logic                   jalr_pc_src,
  input  logic [ADDR_WIDTH-1:0]  imm_op,
  input  logic [ADDR_WIDTH-1:0]  rs1_data,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic [INSTR_WIDTH-1:0] id_instr,
  output logic [ADDR_WIDTH-1:0]  id_pc,
  output logic [ADDR_WIDTH-1:0]  id_pc_plus4,
  output logic                   id_valid,
  output logic                   misaligned,
  output logic [31:0]            fetch_count
);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, next_pc;
  if_id_t                if_id_q, if_id_d;
  logic [31:0]           fetch_count_q, fetch_count_d;
  logic                  bubble, hold, go_halt;

  next_pc_sel #(.AW(ADDR_WIDTH)) u_next_pc_sel (
    .state_i       (state_q),
    .pc_i          (pc_q),
    .id_pc_i       (if_id_q.pc),
    .stall_i       (stall),
    .flush_i       (flush),
    .pc_src_i      (pc_src),
    .jalr_pc_src_i (jalr_pc_src),
    .imm_op_i      (imm_op),
    .rs1_data_i    (rs1_data),
    .next_pc_o     (next_pc),
    .bubble_o      (bubble),
    .hold_o        (hold),
    .go_halt_o     (go_halt)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == RUN && go_halt) state_d = HALT;
  end

  always_comb begin
    misaligned = (state_q == HALT);
  end

  // Bubbles still carry the current PC so branch arithmetic in decode stays defined.
  always_comb begin
    pc_d          = next_pc;
    if_id_d       = if_id_q;
    fetch_count_d = fetch_count_q;
    if (bubble) begin
      if_id_d = '{instr: NOP_INSTR, pc: pc_q, pc_plus4: pc_q + ADDR_WIDTH'(4), valid: 1'b0};
    end else if (!hold) begin
      if_id_d       = '{instr: instr_in, pc: pc_q, pc_plus4: pc_q + ADDR_WIDTH'(4), valid: 1'b1};
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      if_id_q       <= '{instr: NOP_INSTR, pc: '0, pc_plus4: ADDR_WIDTH'(4), valid: 1'b0};
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      if_id_q       <= if_id_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign pc          = pc_q;
  assign id_instr    = if_id_q.instr;
  assign id_pc       = if_id_q.pc;
  assign id_pc_plus4 = if_id_q.pc_plus4;
  assign id_valid    = if_id_q.valid;
  assign fetch_count = fetch_count_q;

endmodule
